auto_player: RTL and testbench

AUTO_PLAYER -- requirements
Module: auto_player

---
 rtl/tow_pkg.sv | 19 +
 rtl/auto_player_if.sv | 19 +
 rtl/ap_lfsr8.sv | 24 ++
 rtl/auto_player.sv | 118 +++++++++++
 tb/tb_auto_player.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war computer player: state encoding and LFSR taps.
package tow_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StReact = 3'd2,
        StPress = 3'd3,
        StDone  = 3'd4
    } ap_state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, as tap positions 7, 5, 4, 3 of a left-shifting register
    localparam logic [7:0] LfsrTaps = 8'hB8;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
        return {q[6:0], ^(q & LfsrTaps)};
    endfunction

endpackage

// File: rtl/auto_player_if.sv
// Match-controller <-> computer-player signal bundle.
interface auto_player_if;
    logic       enable;
    logic       leds_on;
    logic       clear;
    logic       pb_press;
    logic [2:0] state_dbg;
    logic       false_start;

    modport master (
        output enable, leds_on, clear,
        input  pb_press, state_dbg, false_start
    );

    modport slave (
        input  enable, leds_on, clear,
        output pb_press, state_dbg, false_start
    );
endinterface

// File: rtl/ap_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the player's randomness source.
module ap_lfsr8
    import tow_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= SEED;
        end else begin
            r_q <= lfsr8_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/auto_player.sv
// Computer opponent: waits for the go lights, reacts after a pseudo-random delay and holds
// a synthetic button press; occasionally jumps the gun with a deliberate false start.
module auto_player
    import tow_pkg::*;
#(
    parameter int unsigned REACT_MIN       = 20,
    parameter int unsigned REACT_SPAN_BITS = 5,
    parameter int unsigned HOLD_CYC        = 10,
    parameter logic [7:0]  SEED            = 8'hA5,
    parameter bit          FALSE_START_EN  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    auto_player_if.slave   io_ap
);

    localparam int unsigned DelayMax = REACT_MIN + (1 << REACT_SPAN_BITS) - 1;
    localparam int unsigned CntMax   = (DelayMax > HOLD_CYC) ? DelayMax : HOLD_CYC;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    logic [7:0]      w_lfsr;
    ap_state_e       r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [CntW-1:0] r_delay, w_delay_d;
    logic [CntW-1:0] w_arm_delay;
    logic            r_early, w_early_d;
    logic            r_clear;
    logic            w_clear_fall;
    logic            r_pb;
    logic            r_fs, w_fs_d;

    ap_lfsr8 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    assign w_clear_fall = r_clear & ~io_ap.clear;
    assign w_arm_delay  = CntW'(REACT_MIN) + CntW'(w_lfsr[REACT_SPAN_BITS-1:0]);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_delay_d = r_delay;
        w_early_d = r_early;
        w_fs_d    = 1'b0;

        if (!io_ap.enable) begin
            w_state_d = StIdle;
        end else if (w_clear_fall) begin
            // A clear edge wins over leds_on; the lights are looked at from ARMED next cycle.
            w_state_d = StArmed;
            w_delay_d = w_arm_delay;
            w_early_d = FALSE_START_EN && (w_lfsr[7:4] == 4'h0);
        end else if (io_ap.clear && (r_state != StIdle)) begin
            // Round aborted: park in DONE until the clear edge re-arms.
            w_state_d = StDone;
        end else begin
            case (r_state)
                StIdle, StDone: ;
                StArmed: begin
                    if (io_ap.leds_on) begin
                        w_state_d = StReact;
                        w_cnt_d   = r_delay;
                    end else if (r_early) begin
                        w_state_d = StPress;
                        w_cnt_d   = CntW'(HOLD_CYC);
                        w_fs_d    = 1'b1;
                    end
                end
                StReact: begin
                    if (r_cnt <= CntW'(1)) begin
                        w_state_d = StPress;
                        w_cnt_d   = CntW'(HOLD_CYC);
                    end else begin
                        w_cnt_d = r_cnt - CntW'(1);
                    end
                end
                StPress: begin
                    if (r_cnt <= CntW'(1)) begin
                        w_state_d = StDone;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt - CntW'(1);
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_delay <= '0;
            r_early <= 1'b0;
            r_clear <= 1'b0;
            r_pb    <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_delay <= w_delay_d;
            r_early <= w_early_d;
            r_clear <= io_ap.clear;
            r_pb    <= (w_state_d == StPress);
            r_fs    <= w_fs_d;
        end
    end

    assign io_ap.pb_press    = r_pb;
    assign io_ap.state_dbg   = r_state;
    assign io_ap.false_start = r_fs;

endmodule

// File: tb/tb_auto_player.sv
// Randomized scoreboard bench for auto_player: stimulus predicts each press, a monitor checks it.
module tb_auto_player;

    localparam logic [7:0] SEED = 8'hA5;
    localparam int ST_IDLE  = 0;
    localparam int ST_ARMED = 1;
    localparam int ST_PRESS = 3;
    localparam int ST_DONE  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    auto_player_if u_if();

    auto_player #(
        .REACT_MIN       (20),
        .REACT_SPAN_BITS (5),
        .HOLD_CYC        (10),
        .SEED            (SEED),
        .FALSE_START_EN  (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_ap (u_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: the polynomial rule, advancing every clock since reset.
    logic [7:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        int rise;
        int t0;
        int dur;
        bit fs;
    } press_t;

    press_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising pb_press must match the oldest predicted press.
    initial begin
        logic   prev_pb = 1'b0;
        bit     have_cur = 1'b0;
        int     hi_cnt = 0;
        press_t cur;
        forever begin
            @(negedge clk);
            if (u_if.pb_press && !prev_pb) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_press", 1, 0);
                    have_cur = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("press_rise_cycle", cyc, cur.rise);
                    check("false_start_at_rise", int'(u_if.false_start), int'(cur.fs));
                    check("state_at_rise", int'(u_if.state_dbg), ST_PRESS);
                    if (!cur.fs)
                        check("reaction_in_20_51",
                              int'((cyc - cur.t0) >= 20 && (cyc - cur.t0) <= 51), 1);
                end
                hi_cnt = 1;
            end else if (u_if.pb_press) begin
                hi_cnt++;
            end else if (prev_pb && have_cur) begin
                check("press_length", hi_cnt, cur.dur);
            end
            if (u_if.false_start && !(u_if.pb_press && !prev_pb))
                check("spurious_false_start", 1, 0);
            prev_pb = u_if.pb_press;
        end
    end

    int a_cyc;
    int a_delay;
    bit a_early;

    // Pulse clear and drop it when the reference LFSR meets mode's condition
    // (0 any, 1 delay 25 without early, 2 early). Returns at the first ARMED sample.
    task automatic arm(input int mode, input bit coincide);
        int n = 0;
        bit ok = 1'b0;
        @(negedge clk);
        u_if.clear = 1'b1;
        while (!ok && n < 400) begin
            @(negedge clk);
            n++;
            case (mode)
                1:       ok = (m_lfsr[4:0] == 5'd5) && (m_lfsr[7:4] != 4'h0);
                2:       ok = (m_lfsr[7:4] == 4'h0);
                default: ok = 1'b1;
            endcase
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL arm_timeout: got no arm slot, expected one within 400 cycles");
        end
        a_delay = 20 + int'(m_lfsr[4:0]);
        a_early = (m_lfsr[7:4] == 4'h0);
        u_if.clear = 1'b0;
        if (coincide) u_if.leds_on = 1'b1;
        @(negedge clk);
        a_cyc = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Raise the lights w cycles into ARMED (or keep them low for a false start).
    task automatic launch(input int w);
        int t;
        int endc;
        if (a_early && w > 0 && !u_if.leds_on) begin
            exp_q.push_back('{a_cyc + 1, 0, 10, 1'b1});
            endc = a_cyc + 12;
        end else begin
            if (!u_if.leds_on) begin
                repeat (w) @(negedge clk);
                u_if.leds_on = 1'b1;
            end
            t = cyc + 1;
            exp_q.push_back('{t + a_delay, t, 10, 1'b0});
            endc = t + a_delay + 11;
        end
        wait_until(endc);
        check("state_done", int'(u_if.state_dbg), ST_DONE);
        u_if.leds_on = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected one before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        u_if.enable  = 1'b1;
        u_if.leds_on = 1'b0;
        u_if.clear   = 1'b0;
        #1;
        check("reset_state", int'(u_if.state_dbg), ST_IDLE);
        check("reset_pb", int'(u_if.pb_press), 0);
        check("reset_fs", int'(u_if.false_start), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Lights without any clear edge must not start a round
        u_if.leds_on = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_without_clear", int'(u_if.state_dbg), ST_IDLE);
        u_if.leds_on = 1'b0;

        // Delay 25 reaction
        arm(1, 1'b0);
        launch(3);

        // Deliberate false start, lights never come on
        arm(2, 1'b0);
        launch(2);
        repeat (40) @(negedge clk);
        check("done_after_false_start", int'(u_if.state_dbg), ST_DONE);

        // Abort in REACT with the counter at 7, then re-arm with lights coinciding
        arm(0, 1'b0);
        u_if.leds_on = 1'b1;
        t = cyc + 1;
        wait_until(t + a_delay - 7);
        u_if.clear   = 1'b1;
        u_if.leds_on = 1'b0;
        @(negedge clk);
        check("abort_pb_low", int'(u_if.pb_press), 0);
        arm(0, 1'b1);
        check("rearm_state", int'(u_if.state_dbg), ST_ARMED);
        launch(0);

        // Enable dropped mid-press
        arm(0, 1'b1);
        t = a_cyc + 1;
        exp_q.push_back('{t + a_delay, t, 4, 1'b0});
        wait_until(t + a_delay + 3);
        u_if.enable = 1'b0;
        @(negedge clk);
        check("disable_pb_low", int'(u_if.pb_press), 0);
        check("disable_state", int'(u_if.state_dbg), ST_IDLE);
        u_if.leds_on = 1'b0;
        repeat (3) @(negedge clk);
        u_if.enable = 1'b1;
        arm(0, 1'b1);
        check("reenable_armed", int'(u_if.state_dbg), ST_ARMED);
        launch(0);

        // Asynchronous reset mid-press
        arm(0, 1'b1);
        t = a_cyc + 1;
        exp_q.push_back('{t + a_delay, t, 3, 1'b0});
        wait_until(t + a_delay + 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pb", int'(u_if.pb_press), 0);
        check("async_rst_state", int'(u_if.state_dbg), ST_IDLE);
        check("async_rst_lfsr", int'(dut.u_lfsr.q), int'(SEED));
        u_if.leds_on = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_rst", int'(u_if.state_dbg), ST_IDLE);

        // Random rounds
        for (int r = 0; r < 1000; r++) begin
            arm(0, 1'b0);
            launch(int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
